ppu_pattern_gen: RTL and testbench

Synthetic PPU pixel source for the `clk_p` domain. It drives the pixel stream that `hdmi_upscaler` consumes on `rgb_p`, and resynchronises its raster to the upscaler's `new_frame` request. It stands in for the real PPU in upscaler/HDMI bring-up and on-board self-test. It keeps a free-running raster position, latches a pattern mode per frame, and presents pixel colour with a programmable pipeline latency that matches the upscaler's `IPIXEL_LATENCY`.

---
 rtl/ppu_pattern_gen.sv | 134 +++++++++++++
 tb/tb_ppu_pattern_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pattern_gen.sv
// Synthetic PPU pixel source: free-running raster that can be resynchronised to (0,0),
// per-frame latched test pattern, colour delayed by IPIXEL_LATENCY register stages.
module ppu_pattern_gen #(
  parameter int          ISCREEN_WIDTH  = 256,
  parameter int          ISCREEN_HEIGHT = 240,
  parameter int          IFRAME_WIDTH   = 341,
  parameter int          IFRAME_HEIGHT  = 262,
  parameter int unsigned IPIXEL_LATENCY = 1
) (
  input  logic        clk_p,
  input  logic        rst_p_n,
  input  logic        new_frame,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [8:0]  px,
  output logic [8:0]  py,
  output logic [23:0] rgb_p,
  output logic        vblank,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_BORDER   = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_SOLID    = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  localparam logic [8:0] LP_PX_LAST   = 9'(IFRAME_WIDTH - 1);
  localparam logic [8:0] LP_PY_LAST   = 9'(IFRAME_HEIGHT - 1);
  localparam logic [8:0] LP_SW        = 9'(ISCREEN_WIDTH);
  localparam logic [8:0] LP_SH        = 9'(ISCREEN_HEIGHT);
  localparam logic [8:0] LP_SW_LAST   = 9'(ISCREEN_WIDTH - 1);
  localparam logic [8:0] LP_SH_LAST   = 9'(ISCREEN_HEIGHT - 1);
  localparam int         LP_BAR_SHIFT = $clog2(ISCREEN_WIDTH) - 3;

  logic [8:0]  r_px;
  logic [8:0]  r_py;
  logic        r_frame_start;
  logic [15:0] r_frame_cnt;
  mode_e       r_mode_q;
  logic [23:0] r_solid_q;
  logic [23:0] r_pipe [IPIXEL_LATENCY];

  logic        w_at_origin;
  logic        w_frame_evt;
  logic [8:0]  w_px_nxt;
  logic [8:0]  w_py_nxt;
  logic        w_visible;
  logic        w_border;
  logic [2:0]  w_bar;
  logic [7:0]  w_grad_r;
  logic [23:0] w_colour;

  // A restart request while already at (0,0) is dropped so that a held request
  // cannot produce a second frame event.
  assign w_at_origin = (r_px == '0) && (r_py == '0);
  assign w_frame_evt = (new_frame && !w_at_origin) ||
                       ((r_px == LP_PX_LAST) && (r_py == LP_PY_LAST));

  always_comb begin
    w_px_nxt = r_px + 9'd1;
    w_py_nxt = r_py;
    if (w_frame_evt) begin
      w_px_nxt = '0;
      w_py_nxt = '0;
    end else if (r_px == LP_PX_LAST) begin
      w_px_nxt = '0;
      w_py_nxt = r_py + 9'd1;
    end
  end

  always_ff @(posedge clk_p or negedge rst_p_n) begin
    if (!rst_p_n) begin
      r_px          <= '0;
      r_py          <= '0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_mode_q      <= MODE_BORDER;
      r_solid_q     <= '0;
    end else begin
      r_px          <= w_px_nxt;
      r_py          <= w_py_nxt;
      r_frame_start <= w_frame_evt;
      if (w_frame_evt) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_mode_q    <= mode_e'(mode);
        r_solid_q   <= solid_rgb;
      end
    end
  end

  assign w_visible = (r_px < LP_SW) && (r_py < LP_SH);
  assign w_border  = (r_px == '0) || (r_py == '0) ||
                     (r_px == LP_SW_LAST) || (r_py == LP_SH_LAST);
  assign w_bar     = 3'(r_px >> LP_BAR_SHIFT);
  assign w_grad_r  = r_px[7:0] + r_frame_cnt[7:0];

  always_comb begin
    w_colour = '0;
    if (w_visible) begin
      unique case (r_mode_q)
        MODE_BORDER: begin
          if (w_border)
            w_colour = '1;
          else if (r_px[0] ^ r_py[0])
            w_colour = {r_px[7:0], r_py[7:0], 8'h00};
        end
        MODE_BARS:     w_colour = {{8{~w_bar[2]}}, {8{~w_bar[1]}}, {8{~w_bar[0]}}};
        MODE_SOLID:    w_colour = r_solid_q;
        MODE_GRADIENT: w_colour = {w_grad_r, r_py[7:0], r_frame_cnt[7:0]};
        default:       w_colour = '0;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_p_n) begin
    if (!rst_p_n) begin
      for (int unsigned i = 0; i < IPIXEL_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_colour;
      for (int unsigned i = 1; i < IPIXEL_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign px          = r_px;
  assign py          = r_py;
  assign vblank      = (r_py >= LP_SH);
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign rgb_p       = r_pipe[IPIXEL_LATENCY-1];

endmodule

// File: tb/tb_ppu_pattern_gen.sv
// Scoreboard bench for ppu_pattern_gen: a small-frame latency-1 instance and a
// 256-wide latency-3 instance run side by side against a behavioural raster model.
module tb_ppu_pattern_gen;

  localparam int SW0 = 25,  SH0 = 24, FW0 = 33,  FH0 = 26, L0 = 1;
  localparam int SW1 = 256, SH1 = 48, FW1 = 300, FH1 = 60, L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        nf  [2];
  logic [1:0]  md  [2];
  logic [23:0] sol [2];

  logic [8:0]  px0, py0, px1, py1;
  logic [23:0] rgb0, rgb1;
  logic        vb0, vb1, fs0, fs1;
  logic [15:0] fc0, fc1;

  ppu_pattern_gen #(.ISCREEN_WIDTH(SW0), .ISCREEN_HEIGHT(SH0), .IFRAME_WIDTH(FW0),
                    .IFRAME_HEIGHT(FH0), .IPIXEL_LATENCY(L0)) dut0 (
    .clk_p(clk), .rst_p_n(rst_n), .new_frame(nf[0]), .mode(md[0]), .solid_rgb(sol[0]),
    .px(px0), .py(py0), .rgb_p(rgb0), .vblank(vb0), .frame_start(fs0), .frame_cnt(fc0));

  ppu_pattern_gen #(.ISCREEN_WIDTH(SW1), .ISCREEN_HEIGHT(SH1), .IFRAME_WIDTH(FW1),
                    .IFRAME_HEIGHT(FH1), .IPIXEL_LATENCY(L1)) dut1 (
    .clk_p(clk), .rst_p_n(rst_n), .new_frame(nf[1]), .mode(md[1]), .solid_rgb(sol[1]),
    .px(px1), .py(py1), .rgb_p(rgb1), .vblank(vb1), .frame_start(fs1), .frame_cnt(fc1));

  int          nvec  = 0;
  int          nfail = 0;
  int          mx [2];
  int          my [2];
  logic [15:0] mc [2];
  logic [1:0]  mm [2];
  logic [23:0] ms [2];
  logic        mfs [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  function automatic int sw(int k); return (k != 0) ? SW1 : SW0; endfunction
  function automatic int sh(int k); return (k != 0) ? SH1 : SH0; endfunction
  function automatic int fw(int k); return (k != 0) ? FW1 : FW0; endfunction
  function automatic int fh(int k); return (k != 0) ? FH1 : FH0; endfunction
  // width / 8 pixels per bar, expressed as a shift
  function automatic int bs(int k); return (k != 0) ? 5 : 2; endfunction

  function automatic logic [23:0] ref_colour(int k, int x, int y, logic [1:0] m,
                                             logic [23:0] s, logic [15:0] c);
    int b;
    if (x >= sw(k) || y >= sh(k)) return 24'h000000;
    case (m)
      2'd0: begin
        if (x == 0 || y == 0 || x == sw(k) - 1 || y == sh(k) - 1) return 24'hFFFFFF;
        if ((x + y) % 2 == 1) return {8'(x), 8'(y), 8'h00};
        return 24'h000000;
      end
      2'd1: begin
        b = (x >> bs(k)) & 7;
        return {((b & 4) != 0) ? 8'h00 : 8'hFF,
                ((b & 2) != 0) ? 8'h00 : 8'hFF,
                ((b & 1) != 0) ? 8'h00 : 8'hFF};
      end
      2'd2:    return s;
      default: return {8'(x + int'(c[7:0])), 8'(y), c[7:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic reinit();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 0; my[k] = 0; mc[k] = '0; mm[k] = '0; ms[k] = '0; mfs[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
    repeat (L0) q0.push_back(24'h0);
    repeat (L1) q1.push_back(24'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_px0"}, 24'(px0), 24'h0);  chk({tag, "_py0"}, 24'(py0), 24'h0);
    chk({tag, "_rgb0"}, rgb0, 24'h0);     chk({tag, "_fc0"}, 24'(fc0), 24'h0);
    chk({tag, "_fs0"}, 24'(fs0), 24'h0);  chk({tag, "_vb0"}, 24'(vb0), 24'h0);
    chk({tag, "_px1"}, 24'(px1), 24'h0);  chk({tag, "_py1"}, 24'(py1), 24'h0);
    chk({tag, "_rgb1"}, rgb1, 24'h0);     chk({tag, "_fc1"}, 24'(fc1), 24'h0);
    chk({tag, "_fs1"}, 24'(fs1), 24'h0);  chk({tag, "_vb1"}, 24'(vb1), 24'h0);
  endtask

  // Compare the current cycle against the model, push this cycle's colour,
  // then advance the model with the inputs about to be clocked in.
  task automatic tick();
    logic [23:0] e;
    bit          restart, wrap;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("px%0d", k),  24'((k != 0) ? px1 : px0), 24'(mx[k]));
      chk($sformatf("py%0d", k),  24'((k != 0) ? py1 : py0), 24'(my[k]));
      chk($sformatf("fs%0d", k),  24'((k != 0) ? fs1 : fs0), 24'(mfs[k]));
      chk($sformatf("fc%0d", k),  24'((k != 0) ? fc1 : fc0), 24'(mc[k]));
      chk($sformatf("vb%0d", k),  24'((k != 0) ? vb1 : vb0), (my[k] >= sh(k)) ? 24'h1 : 24'h0);
      e = ref_colour(k, mx[k], my[k], mm[k], ms[k], mc[k]);
      if (k == 0) begin
        chk("rgb0", rgb0, q0.pop_front());
        q0.push_back(e);
      end else begin
        chk("rgb1", rgb1, q1.pop_front());
        q1.push_back(e);
      end
      restart = nf[k] && !(mx[k] == 0 && my[k] == 0);
      wrap    = (mx[k] == fw(k) - 1) && (my[k] == fh(k) - 1);
      if (restart || wrap) begin
        mx[k] = 0; my[k] = 0; mc[k] = mc[k] + 16'd1;
        mm[k] = md[k]; ms[k] = sol[k]; mfs[k] = 1'b1;
      end else begin
        mfs[k] = 1'b0;
        if (mx[k] == fw(k) - 1) begin
          mx[k] = 0; my[k] = my[k] + 1;
        end else begin
          mx[k] = mx[k] + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(input int k, input int x, input int y);
    int n = 0;
    while (!(mx[k] == x && my[k] == y) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      nfail++;
      $error("FAIL run_to%0d observed=(%0d,%0d) expected=(%0d,%0d)", k, mx[k], my[k], x, y);
    end
  endtask

  initial begin
    #900000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin nf[k] = 1'b0; md[k] = 2'd0; sol[k] = 24'h0; end
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    reinit();

    // Mode 0 border/checker on the small screen
    run_to(0, 5, 0);  tick(); chk("row0_border", rgb0, 24'hFFFFFF);
    run_to(0, 4, 4);  tick(); chk("even_4_4", rgb0, 24'h000000);
    run_to(0, 3, 6);  tick(); chk("odd_3_6", rgb0, 24'h030600);
    run_to(0, 0, 0);
    chk("wrap_fs", 24'(fs0), 24'h1);
    chk("wrap_fc", 24'(fc0), 24'h1);

    // new_frame restart, then a request held across (0,0)
    run_to(0, 10, 5); nf[0] = 1'b1; tick(); nf[0] = 1'b0;
    chk("nf_px", 24'(px0), 24'h0); chk("nf_py", 24'(py0), 24'h0);
    chk("nf_fs", 24'(fs0), 24'h1); chk("nf_fc", 24'(fc0), 24'h2);
    run_to(0, 10, 5); nf[0] = 1'b1; tick(); tick(); nf[0] = 1'b0;
    chk("hold_px", 24'(px0), 24'h1); chk("hold_py", 24'(py0), 24'h0);
    chk("hold_fs", 24'(fs0), 24'h0); chk("hold_fc", 24'(fc0), 24'h3);

    // Mid-frame mode change takes effect only at the next frame
    run_to(0, 10, 3); md[0] = 2'd2; sol[0] = 24'h123456;
    run_to(0, 11, 4); tick(); chk("old_mode", rgb0, 24'h0B0400);
    run_to(0, 0, 0);  tick(); chk("new_solid", rgb0, 24'h123456);
    run_to(0, 26, 0); tick(); chk("blank_solid", rgb0, 24'h000000);

    // Colour bars at 256 width, latency 3
    md[1] = 2'd1; nf[1] = 1'b1; tick(); nf[1] = 1'b0;
    chk("bars_fs", 24'(fs1), 24'h1);
    repeat (3) tick(); chk("bar0", rgb1, 24'hFFFFFF);
    run_to(1, 32, 0);  repeat (3) tick(); chk("bar1", rgb1, 24'hFFFF00);
    run_to(1, 224, 0); repeat (3) tick(); chk("bar7", rgb1, 24'h000000);

    // Gradient in frame 5
    guard = 0;
    while (mc[1] != 16'd5 && guard < 10) begin
      if (mc[1] == 16'd4) md[1] = 2'd3;
      nf[1] = 1'b1; tick(); nf[1] = 1'b0; tick();
      guard++;
    end
    chk("frame5", 24'(fc1), 24'h5);
    run_to(1, 2, 7); repeat (3) tick(); chk("grad_2_7", rgb1, 24'h070705);

    // Asynchronous reset mid-frame
    run_to(1, 100, 50);
    chk("pre_rst_vb", 24'(vb1), 24'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    @(posedge clk);
    #1 chk_zero("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    reinit();
    repeat (40) tick();
    chk("post_rst_fc", 24'(fc1), 24'h0);
    chk("post_rst_mode0", rgb1, 24'hFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
